// File: rtl/bus_arb.sv
// bus_arb: arbitrates an instruction-fetch port (IFU) and a load/store port
// (LSU) onto one downstream memory request/response channel. Only one
// transaction is outstanding at a time; each requester owns one pending slot.
//
// Ports
//   clock, reset_n                 clock, async active-low reset
//   ifu_reqValid, ifu_addr         fetch request pulse + address
//   ifu_respValid, ifu_rdata,      fetch response pulse, data, timeout flag
//   ifu_err
//   lsu_reqValid, lsu_wen,         load/store request pulse + fields
//   lsu_addr, lsu_wdata, lsu_wmask
//   lsu_respValid, lsu_rdata,      load/store response pulse, data (0 for
//   lsu_err                        stores), timeout flag
//   mem_reqValid, mem_reqReady     downstream request handshake
//   mem_addr, mem_wdata,           downstream request fields (0 when idle,
//   mem_wen, mem_wmask             wmask 0 for reads)
//   mem_respValid, mem_rdata       downstream response pulse + data
//   proto_err                      sticky: request from a busy requester
module bus_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_reqValid,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_reqValid,
  input  logic        mem_reqReady,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } slot_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  slot_t       ifu_slot, lsu_slot, cur;
  logic        ifu_pend, lsu_pend;
  logic        ifu_acc, lsu_acc;
  logic        sel_lsu;
  logic        err_q;
  logic [31:0] data_q;
  logic [15:0] cnt;
  logic        to_hit;

  // A slot stays occupied from capture until its RESP cycle, so "pending or
  // active" is simply the occupied bit.
  assign ifu_acc = ifu_reqValid && !ifu_pend;
  assign lsu_acc = lsu_reqValid && !lsu_pend;
  assign to_hit  = (cnt == TO_LAST);
  assign cur     = sel_lsu ? lsu_slot : ifu_slot;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (ifu_pend || lsu_pend || ifu_acc || lsu_acc) state_nx = REQ;
      // Timeout wins over a same-cycle accept: the transaction is abandoned
      // and any response to it lands outside WAIT and is ignored.
      REQ:  if (to_hit) state_nx = RESP;
            else if (mem_reqReady) state_nx = WAIT;
      // A response arriving on the timeout cycle is still real data; keep it.
      WAIT: if (mem_respValid || to_hit) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ifu_pend  <= 1'b0;
      lsu_pend  <= 1'b0;
      ifu_slot  <= '0;
      lsu_slot  <= '0;
      sel_lsu   <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      cnt       <= '0;
      proto_err <= 1'b0;
    end else begin
      if ((ifu_reqValid && ifu_pend) || (lsu_reqValid && lsu_pend))
        proto_err <= 1'b1;
      if (ifu_acc) begin
        ifu_pend      <= 1'b1;
        ifu_slot.addr <= ifu_addr;
      end
      if (lsu_acc) begin
        lsu_pend <= 1'b1;
        lsu_slot <= '{wen: lsu_wen, addr: lsu_addr, wdata: lsu_wdata, wmask: lsu_wmask};
      end
      case (state)
        IDLE: begin
          // Selection is only consumed when leaving IDLE; LSU has priority.
          sel_lsu <= lsu_pend || lsu_acc;
          cnt     <= '0;
          err_q   <= 1'b0;
          data_q  <= '0;
        end
        REQ: begin
          cnt <= cnt + 16'd1;
          if (to_hit) begin
            err_q  <= 1'b1;
            data_q <= '0;
          end
        end
        WAIT: begin
          cnt <= cnt + 16'd1;
          if (mem_respValid) begin
            err_q  <= 1'b0;
            data_q <= cur.wen ? 32'd0 : mem_rdata;
          end else if (to_hit) begin
            err_q  <= 1'b1;
            data_q <= '0;
          end
        end
        RESP: begin
          if (sel_lsu) lsu_pend <= 1'b0;
          else         ifu_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ifu_respValid = (state == RESP) && !sel_lsu;
  assign lsu_respValid = (state == RESP) && sel_lsu;
  assign ifu_err       = ifu_respValid && err_q;
  assign lsu_err       = lsu_respValid && err_q;
  assign ifu_rdata     = ifu_respValid ? data_q : 32'd0;
  assign lsu_rdata     = lsu_respValid ? data_q : 32'd0;

  assign mem_reqValid  = (state == REQ);
  assign mem_addr      = mem_reqValid ? cur.addr : 32'd0;
  assign mem_wen       = mem_reqValid && cur.wen;
  assign mem_wdata     = mem_wen ? cur.wdata : 32'd0;
  assign mem_wmask     = mem_wen ? cur.wmask : 4'd0;

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb built with TIMEOUT=4. Inputs change 1 time unit
// after a rising edge; outputs (all register-derived) are checked there too.
module tb_bus_arb;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ifu_reqValid = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        ifu_err;
  logic        lsu_reqValid = 1'b0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        mem_reqValid;
  logic        mem_reqReady = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic        mem_respValid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        proto_err;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  bus_arb #(.TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_reqValid(lsu_reqValid), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_reqValid(mem_reqValid), .mem_reqReady(mem_reqReady),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_wmask(mem_wmask), .mem_respValid(mem_respValid),
    .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step(); step();
    ifu_reqValid = 1'b1; ifu_addr = 32'h0000_0AAA;
    step();
    ifu_reqValid = 1'b0;
    checks++;
    if ({mem_reqValid, ifu_respValid, lsu_respValid, proto_err, mem_wen} !== 5'b0 || mem_addr !== 32'h0)
      begin $display("FAIL reset_outputs: req=%b ifu=%b lsu=%b perr=%b addr=%h required all 0",
        mem_reqValid, ifu_respValid, lsu_respValid, proto_err, mem_addr); errors++; end
    reset_n = 1'b1;
    step();
    checks++;
    if (mem_reqValid !== 1'b0)
      begin $display("FAIL reset_no_capture: mem_reqValid=%b required 0", mem_reqValid); errors++; end
  endtask

  task automatic test_ifu_fetch();
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0000;
    step();
    ifu_reqValid = 1'b0;
    checks++;
    if (mem_reqValid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wmask !== 4'h0)
      begin $display("FAIL fetch_req: valid=%b addr=%h wmask=%h required 1 80000000 0",
        mem_reqValid, mem_addr, mem_wmask); errors++; end
    mem_reqReady = 1'b1;
    step();
    mem_reqReady = 1'b0;
    checks++;
    if (mem_reqValid !== 1'b0 || ifu_respValid !== 1'b0)
      begin $display("FAIL fetch_wait: valid=%b resp=%b required 0 0", mem_reqValid, ifu_respValid); errors++; end
    mem_respValid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_respValid = 1'b0; mem_rdata = '0;
    checks++;
    if (ifu_respValid !== 1'b1 || ifu_rdata !== 32'hDEAD_BEEF || ifu_err !== 1'b0 || lsu_respValid !== 1'b0)
      begin $display("FAIL fetch_resp: resp=%b data=%h err=%b lsu=%b required 1 deadbeef 0 0",
        ifu_respValid, ifu_rdata, ifu_err, lsu_respValid); errors++; end
    step();
    checks++;
    if (ifu_respValid !== 1'b0 || ifu_rdata !== 32'h0)
      begin $display("FAIL fetch_one_pulse: resp=%b data=%h required 0 0", ifu_respValid, ifu_rdata); errors++; end
  endtask

  task automatic test_priority();
    ifu_reqValid = 1'b1; ifu_addr = 32'h100;
    lsu_reqValid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h200; lsu_wdata = 32'h5555_5555; lsu_wmask = 4'hF;
    step();
    ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
    checks++;
    if (mem_reqValid !== 1'b1 || mem_addr !== 32'h200 || mem_wen !== 1'b0 || mem_wmask !== 4'h0)
      begin $display("FAIL prio_first: valid=%b addr=%h wen=%b wmask=%h required 1 200 0 0",
        mem_reqValid, mem_addr, mem_wen, mem_wmask); errors++; end
    mem_reqReady = 1'b1;
    step();
    mem_reqReady = 1'b0;
    mem_respValid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_respValid = 1'b0; mem_rdata = '0;
    checks++;
    if (lsu_respValid !== 1'b1 || lsu_rdata !== 32'h1234_5678 || ifu_respValid !== 1'b0 || ifu_rdata !== 32'h0)
      begin $display("FAIL prio_lsu_resp: lsu=%b data=%h ifu=%b ifu_data=%h required 1 12345678 0 0",
        lsu_respValid, lsu_rdata, ifu_respValid, ifu_rdata); errors++; end
    step();
    checks++;
    if (mem_reqValid !== 1'b0 || lsu_respValid !== 1'b0)
      begin $display("FAIL prio_idle: valid=%b lsu=%b required 0 0", mem_reqValid, lsu_respValid); errors++; end
    step();
    checks++;
    if (mem_reqValid !== 1'b1 || mem_addr !== 32'h100)
      begin $display("FAIL prio_second: valid=%b addr=%h required 1 100", mem_reqValid, mem_addr); errors++; end
    mem_reqReady = 1'b1;
    step();
    mem_reqReady = 1'b0;
    mem_respValid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_respValid = 1'b0; mem_rdata = '0;
    checks++;
    if (ifu_respValid !== 1'b1 || ifu_rdata !== 32'hCAFE_F00D || lsu_respValid !== 1'b0 || lsu_rdata !== 32'h0)
      begin $display("FAIL prio_ifu_resp: ifu=%b data=%h lsu=%b lsu_data=%h required 1 cafef00d 0 0",
        ifu_respValid, ifu_rdata, lsu_respValid, lsu_rdata); errors++; end
    step();
  endtask

  task automatic test_store();
    lsu_reqValid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h1000_0000; lsu_wdata = 32'h41; lsu_wmask = 4'h1;
    step();
    lsu_reqValid = 1'b0; lsu_wen = 1'b0;
    checks++;
    if (mem_reqValid !== 1'b1 || mem_addr !== 32'h1000_0000 || mem_wen !== 1'b1 || mem_wmask !== 4'h1 || mem_wdata !== 32'h41)
      begin $display("FAIL store_req: valid=%b addr=%h wen=%b wmask=%h wdata=%h required 1 10000000 1 1 41",
        mem_reqValid, mem_addr, mem_wen, mem_wmask, mem_wdata); errors++; end
    mem_reqReady = 1'b1;
    step();
    mem_reqReady = 1'b0;
    mem_respValid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_respValid = 1'b0; mem_rdata = '0;
    checks++;
    if (lsu_respValid !== 1'b1 || lsu_rdata !== 32'h0 || lsu_err !== 1'b0)
      begin $display("FAIL store_resp: resp=%b data=%h err=%b required 1 0 0",
        lsu_respValid, lsu_rdata, lsu_err); errors++; end
    step();
  endtask

  task automatic test_timeout();
    lsu_reqValid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h300; lsu_wmask = 4'hF;
    step();                   // first REQ cycle
    lsu_reqValid = 1'b0;
    step(); step(); step();   // REQ cycles 2..4, still stalled
    checks++;
    if (mem_reqValid !== 1'b1 || lsu_respValid !== 1'b0)
      begin $display("FAIL timeout_still_req: valid=%b resp=%b required 1 0", mem_reqValid, lsu_respValid); errors++; end
    step();                   // four cycles after REQ entry
    checks++;
    if (lsu_respValid !== 1'b1 || lsu_err !== 1'b1 || lsu_rdata !== 32'h0 || ifu_respValid !== 1'b0 || ifu_err !== 1'b0)
      begin $display("FAIL timeout_resp: resp=%b err=%b data=%h ifu=%b ifu_err=%b required 1 1 0 0 0",
        lsu_respValid, lsu_err, lsu_rdata, ifu_respValid, ifu_err); errors++; end
    step();
    mem_respValid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    step();
    mem_respValid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (lsu_respValid !== 1'b0 || ifu_respValid !== 1'b0 || mem_reqValid !== 1'b0 || lsu_err !== 1'b0)
        begin $display("FAIL timeout_late_ignored[%0d]: lsu=%b ifu=%b req=%b err=%b required 0 0 0 0",
          i, lsu_respValid, ifu_respValid, mem_reqValid, lsu_err); errors++; end
      step();
    end
  endtask

  task automatic test_proto_err();
    checks++;
    if (proto_err !== 1'b0)
      begin $display("FAIL proto_clean: proto_err=%b required 0", proto_err); errors++; end
    ifu_reqValid = 1'b1; ifu_addr = 32'h4000;
    step();
    ifu_addr = 32'h5000;      // second pulse while active
    step();
    ifu_reqValid = 1'b0;
    checks++;
    if (proto_err !== 1'b1 || mem_reqValid !== 1'b1 || mem_addr !== 32'h4000)
      begin $display("FAIL proto_drop: perr=%b valid=%b addr=%h required 1 1 4000",
        proto_err, mem_reqValid, mem_addr); errors++; end
    mem_reqReady = 1'b1;
    step();
    mem_reqReady = 1'b0;
    mem_respValid = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_respValid = 1'b0; mem_rdata = '0;
    checks++;
    if (ifu_respValid !== 1'b1 || ifu_rdata !== 32'h1111_2222)
      begin $display("FAIL proto_resp: resp=%b data=%h required 1 11112222", ifu_respValid, ifu_rdata); errors++; end
    step(); step();
    checks++;
    if (proto_err !== 1'b1 || mem_reqValid !== 1'b0)
      begin $display("FAIL proto_sticky: perr=%b valid=%b required 1 0", proto_err, mem_reqValid); errors++; end
  endtask

  task automatic test_reset_mid();
    ifu_reqValid = 1'b1; ifu_addr = 32'h6000;
    lsu_reqValid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h7000;
    step();
    ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
    mem_reqReady = 1'b1;
    step();                   // WAIT for the LSU load, IFU still pending
    mem_reqReady = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({proto_err, mem_reqValid, ifu_respValid, lsu_respValid} !== 4'b0 || mem_addr !== 32'h0)
      begin $display("FAIL reset_async: perr=%b req=%b ifu=%b lsu=%b addr=%h required all 0",
        proto_err, mem_reqValid, ifu_respValid, lsu_respValid, mem_addr); errors++; end
    step();
    reset_n = 1'b1;
    mem_respValid = 1'b1; mem_rdata = 32'h7777_7777;
    step();
    mem_respValid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ifu_respValid, lsu_respValid, mem_reqValid, proto_err} !== 4'b0 || lsu_rdata !== 32'h0)
        begin $display("FAIL reset_discard[%0d]: ifu=%b lsu=%b req=%b perr=%b data=%h required all 0",
          i, ifu_respValid, lsu_respValid, mem_reqValid, proto_err, lsu_rdata); errors++; end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_ifu_fetch();
    test_priority();
    test_store();
    test_timeout();
    test_proto_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Parameters
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of cycles in REQ+WAIT before a transaction is aborted with an error (range 2..65535).

Interface
REQ-002 clock  in  1  rising-edge clock.
REQ-003 reset_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 ifu_reqValid  in  1  one-cycle fetch request pulse.
REQ-005 ifu_addr  in  32  fetch address, sampled with ifu_reqValid.
REQ-006 ifu_respValid  out  1  one-cycle fetch response pulse.
REQ-007 ifu_rdata  out  32  fetch data, valid with ifu_respValid.
REQ-008 lsu_reqValid  in  1  one-cycle load/store request pulse.
REQ-009 lsu_wen  in  1  1=store, 0=load, sampled with lsu_reqValid.
REQ-010 lsu_addr / lsu_wdata  in  32 / 32  address and store data, sampled with lsu_reqValid.
REQ-011 lsu_wmask  in  4  byte-lane strobe, sampled with lsu_reqValid.
REQ-012 lsu_respValid  out  1  one-cycle load/store response pulse.
REQ-013 lsu_rdata  out  32  load data, valid with lsu_respValid; 0 for stores.
REQ-014 ifu_err / lsu_err  out  1  high with the respective respValid when the transaction timed out.
REQ-015 mem_reqValid  out  1  downstream request, held until accepted.
REQ-016 mem_reqReady  in  1  downstream accept; handshake when mem_reqValid&&mem_reqReady.
REQ-017 mem_addr / mem_wdata  out  32 / 32  downstream address and write data.
REQ-018 mem_wen / mem_wmask  out  1 / 4  downstream write enable and strobe; wmask=0 for reads.
REQ-019 mem_respValid / mem_rdata  in  1 / 32  downstream response pulse and data.
REQ-020 proto_err  out  1  sticky: a request arrived from a requester already pending or active.

Function
REQ-021 Each requester SHALL have one pending slot capturing addr/wen/wdata/wmask on its reqValid pulse when the slot is free and the requester is not active.
REQ-022 A reqValid from a requester already pending or active SHALL be dropped and SHALL set proto_err.
REQ-023 States: IDLE, REQ, WAIT, RESP; one transaction outstanding at a time.
REQ-024 IDLE: if any request is pending or arriving this cycle, select and go to REQ next cycle; else stay IDLE.
REQ-025 Selection: LSU over IFU when both are pending/arriving in the same cycle; the loser stays pending.
REQ-026 REQ: mem_reqValid=1 with the selected fields stable; on mem_reqReady=1 go to WAIT.
REQ-027 WAIT: on mem_respValid=1 capture mem_rdata (loads/fetches) and go to RESP.
REQ-028 RESP: assert the selected requester's respValid for exactly one cycle with registered data, free its slot, go IDLE.
REQ-029 Minimum latency: reqValid at cycle N, mem_reqValid at N+1, ready at N+1, mem_respValid at N+2, respValid at N+3.
REQ-030 A 16-bit timeout counter SHALL clear on entering REQ and increment in REQ and WAIT; at count TIMEOUT-1 go to RESP with err=1 and rdata=0.
REQ-031 mem_respValid outside WAIT SHALL be ignored, including late responses after a timeout.
REQ-032 Only the addressed requester's respValid/err SHALL change; the other requester's outputs stay 0.

Reset
REQ-033 While reset_n=0: state IDLE, slots empty, counter 0, proto_err 0, all outputs 0, independent of clock.
REQ-034 Reset mid-transaction SHALL discard all pending/active work; no response is issued for it afterward.

Verification
REQ-035 IFU fetch 0x8000_0000, mem ready immediately, resp 0xDEAD_BEEF one cycle later -> ifu_respValid at N+3, ifu_rdata=0xDEAD_BEEF, ifu_err=0.
REQ-036 Same-cycle IFU 0x100 and LSU load 0x200 -> mem_addr=0x200 first, lsu_respValid, then mem_addr=0x100, ifu_respValid.
REQ-037 LSU store 0x1000_0000 wdata=0x41 wmask=0x1 -> mem_wen=1, mem_wmask=0x1, lsu_respValid with lsu_rdata=0.
REQ-038 TIMEOUT=4, mem_reqReady held 0 -> lsu_respValid with lsu_err=1 and lsu_rdata=0 four cycles after REQ entry; later mem_respValid is ignored.
REQ-039 Second ifu_reqValid while a fetch is active -> dropped, proto_err=1 and held until reset.
REQ-040 reset_n low during WAIT, then mem_respValid after release -> no respValid, state IDLE, outputs 0.
